// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the dmem arbiter: FSM state encoding and port-owner codes.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'b00,
    HOLD_REQ = 2'b01,
    EXT_OWN  = 2'b10,
    RELEASE  = 2'b11
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

endpackage

// File: rtl/dmem_arbiter_arb_count.sv
// Loadable saturating up/down counter; used for the burst beat count and the
// post-release cooldown window.
module arb_count
  import dmem_arbiter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  // Load beats inc beats dec; both directions stick at their end values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the core (default owner) and one external
// master, using the core's hold/hold_ack stall handshake and bounded bursts.
//
//   state    | meaning
//   CPU_OWN  | core drives dmem; cooldown counts down, ext_req honoured at 0
//   HOLD_REQ | core asked to stall; core still drives dmem until it acks
//   EXT_OWN  | external master drives dmem, one beat per cycle with ext_req
//   RELEASE  | grant dropped, no writes this cycle, cooldown reloaded
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDE      = 32,
  parameter int MAX_BURST = 16,
  parameter int COOLDOWN  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_we,
  input  logic [31:0]     cpu_a,
  input  logic [WIDE-1:0] cpu_d,
  output logic [WIDE-1:0] cpu_q,
  output logic            hold,
  input  logic            hold_ack,
  input  logic            ext_req,
  input  logic            ext_we,
  input  logic [31:0]     ext_a,
  input  logic [WIDE-1:0] ext_d,
  output logic            ext_gnt,
  output logic [WIDE-1:0] ext_q,
  output logic            mem_we,
  output logic [31:0]     mem_a,
  output logic [WIDE-1:0] mem_d,
  input  logic [WIDE-1:0] mem_q,
  output logic            cpu_wr_drop
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1);

  arb_state_t    state;
  logic [BW-1:0] beat;
  logic [CW-1:0] cool;
  logic          xfer;
  logic          last_beat;
  logic          owner;

  assign xfer      = (state == EXT_OWN) && ext_req;
  assign last_beat = xfer && (beat == BW'(MAX_BURST - 1));

  // A dropped request wins over a same-cycle ack: nothing left to grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CPU_OWN;
    end else begin
      case (state)
        CPU_OWN:  if (ext_req && (cool == '0)) state <= HOLD_REQ;
        HOLD_REQ: begin
          if (!ext_req)      state <= CPU_OWN;
          else if (hold_ack) state <= EXT_OWN;
        end
        EXT_OWN:  if (!ext_req || last_beat) state <= RELEASE;
        RELEASE:  state <= CPU_OWN;
        default:  state <= CPU_OWN;
      endcase
    end
  end

  arb_count #(.W(BW)) u_beat (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == HOLD_REQ) && hold_ack),
    .load_val ('0),
    .inc      (xfer),
    .dec      (1'b0),
    .count    (beat)
  );

  arb_count #(.W(CW)) u_cool (
    .clk      (clk),
    .rst      (rst),
    .load     (state == RELEASE),
    .load_val (CW'(COOLDOWN)),
    .inc      (1'b0),
    .dec      (state == CPU_OWN),
    .count    (cool)
  );

  assign owner       = (state == EXT_OWN) ? OWNER_EXT : OWNER_CPU;
  assign hold        = (state == HOLD_REQ) || (state == EXT_OWN);
  assign ext_gnt     = (state == EXT_OWN);
  assign cpu_wr_drop = cpu_we && ((state == EXT_OWN) || (state == RELEASE));

  assign mem_a = (owner == OWNER_EXT) ? ext_a : cpu_a;
  assign mem_d = (owner == OWNER_EXT) ? ext_d : cpu_d;

  // Reset also blocks the write on its own edge so an interrupted burst
  // cannot land a beat while being torn down.
  always_comb begin
    mem_we = 1'b0;
    case (state)
      CPU_OWN, HOLD_REQ: mem_we = cpu_we;
      EXT_OWN:           mem_we = ext_we && ext_req;
      default:           mem_we = 1'b0;
    endcase
    if (rst) mem_we = 1'b0;
  end

  assign cpu_q = mem_q;
  assign ext_q = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (WIDE=32, MAX_BURST=16, COOLDOWN=4) with a
// small word-addressed dmem model behind the arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [31:0] cpu_a;
  logic [31:0] cpu_d;
  logic [31:0] cpu_q;
  logic        hold;
  logic        hold_ack;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_a;
  logic [31:0] ext_d;
  logic        ext_gnt;
  logic [31:0] ext_q;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_d;
  logic [31:0] mem_q;
  logic        cpu_wr_drop;

  logic [31:0] mem [0:255];
  logic        mem_clr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDE(32), .MAX_BURST(16), .COOLDOWN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_we      (cpu_we),
    .cpu_a       (cpu_a),
    .cpu_d       (cpu_d),
    .cpu_q       (cpu_q),
    .hold        (hold),
    .hold_ack    (hold_ack),
    .ext_req     (ext_req),
    .ext_we      (ext_we),
    .ext_a       (ext_a),
    .ext_d       (ext_d),
    .ext_gnt     (ext_gnt),
    .ext_q       (ext_q),
    .mem_we      (mem_we),
    .mem_a       (mem_a),
    .mem_d       (mem_d),
    .mem_q       (mem_q),
    .cpu_wr_drop (cpu_wr_drop)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_a[9:2]] <= mem_d;
    end
  end
  assign mem_q = mem[mem_a[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    cpu_we = 1'b0; cpu_a = 32'h0; cpu_d = 32'h0;
    hold_ack = 1'b0; ext_req = 1'b0; ext_we = 1'b0; ext_a = 32'h0; ext_d = 32'h0;
    tick(); tick();
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    chk("rst_hold", hold, 1'b0);
    chk("rst_gnt", ext_gnt, 1'b0);
    chk("rst_drop", cpu_wr_drop, 1'b0);
    chk("rst_we", mem_we, 1'b0);

    // CPU-only traffic
    cpu_a = 32'h10; cpu_d = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      logic exp_we;
      exp_we = (i != 1);
      cpu_we = exp_we;
      #1;
      chk("cpu_mem_we", mem_we, exp_we);
      chk("cpu_mem_a", mem_a, 32'h10);
      chk("cpu_mem_d", mem_d, 32'hA5A5A5A5);
      chk("cpu_hold", hold, 1'b0);
      chk("cpu_gnt", ext_gnt, 1'b0);
      tick();
    end
    cpu_we = 1'b0;
    #1;
    chk("cpu_word", mem[4], 32'hA5A5A5A5);

    // 4-beat external write burst, ack already high
    hold_ack = 1'b1; ext_req = 1'b1; ext_we = 1'b1;
    ext_a = 32'h100; ext_d = 32'h1000_0000;
    #1;
    chk("b4_c0_hold", hold, 1'b0);
    tick();
    chk("b4_c1_hold", hold, 1'b1);
    chk("b4_c1_gnt", ext_gnt, 1'b0);
    chk("b4_c1_mem_a", mem_a, 32'h10);
    chk("b4_c1_we", mem_we, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      ext_a = 32'h100 + 32'(4 * i);
      ext_d = 32'h1000_0000 + 32'(i);
      #1;
      chk("b4_gnt", ext_gnt, 1'b1);
      chk("b4_we", mem_we, 1'b1);
      chk("b4_mem_a", mem_a, 32'h100 + 32'(4 * i));
      tick();
    end
    ext_req = 1'b0;
    #1;
    chk("b4_idle_gnt", ext_gnt, 1'b1);
    chk("b4_idle_we", mem_we, 1'b0);
    tick();
    ext_req = 1'b1; ext_we = 1'b0; ext_a = 32'h100;
    #1;
    chk("rel_hold", hold, 1'b0);
    chk("rel_gnt", ext_gnt, 1'b0);
    chk("rel_we", mem_we, 1'b0);
    chk("rel_mem_a", mem_a, 32'h10);
    for (int i = 0; i < 4; i++) chk("b4_word", mem[64 + i], 32'h1000_0000 + 32'(i));
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("cool_hold", hold, 1'b0);
      tick();
    end
    chk("cool_rehold", hold, 1'b1);

    // Continuous request: burst capped at 16 reads
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("cap_gnt", ext_gnt, 1'b1);
      if (i == 0) chk("cap_ext_q", ext_q, 32'h1000_0000);
      tick();
    end
    chk("cap_rel_gnt", ext_gnt, 1'b0);
    chk("cap_rel_hold", hold, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("cap_cool_hold", hold, 1'b0);
      tick();
    end
    chk("cap_rehold", hold, 1'b1);

    // Abort from HOLD_REQ
    ext_req = 1'b0; hold_ack = 1'b0;
    tick();
    chk("abort_hold", hold, 1'b0);
    chk("abort_gnt", ext_gnt, 1'b0);

    // Late ack, request withdrawn at cycle 3, no cooldown afterwards
    ext_req = 1'b1;
    tick();
    chk("late_c1_hold", hold, 1'b1);
    chk("late_c1_gnt", ext_gnt, 1'b0);
    tick();
    chk("late_c2_gnt", ext_gnt, 1'b0);
    tick();
    ext_req = 1'b0;
    #1;
    chk("late_c3_gnt", ext_gnt, 1'b0);
    tick();
    chk("late_ret_hold", hold, 1'b0);
    chk("late_ret_gnt", ext_gnt, 1'b0);
    ext_req = 1'b1;
    tick();
    chk("nocool_hold", hold, 1'b1);

    // Core write during EXT_OWN is dropped; reset on the 3rd beat
    hold_ack = 1'b1; ext_we = 1'b1; ext_a = 32'h200; ext_d = 32'h55;
    tick();
    cpu_we = 1'b1; cpu_a = 32'h20; cpu_d = 32'hDEADBEEF;
    #1;
    chk("drop_pulse", cpu_wr_drop, 1'b1);
    chk("drop_mem_a", mem_a, 32'h200);
    chk("drop_mem_d", mem_d, 32'h55);
    tick();
    cpu_we = 1'b0; ext_a = 32'h204; ext_d = 32'h66;
    #1;
    chk("drop_end", cpu_wr_drop, 1'b0);
    chk("beat2_gnt", ext_gnt, 1'b1);
    tick();
    ext_a = 32'h208; ext_d = 32'h77; rst = 1'b1;
    #1;
    chk("rstb_we", mem_we, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstb_hold", hold, 1'b0);
    chk("rstb_gnt", ext_gnt, 1'b0);
    chk("rstb_cpu_word", mem[8], 32'h0);
    chk("rstb_w0", mem[128], 32'h55);
    chk("rstb_w1", mem[129], 32'h66);
    chk("rstb_w2", mem[130], 32'h0);
    tick();
    chk("rstb_rereq", hold, 1'b1);
    ext_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
